// File: rtl/proc_io_in_fifo.sv
// rtl/proc_io_in_fifo.sv - per-channel input FIFOs feeding the processor io_in port
//
// Purpose: one small FIFO per processor input address. Producers push samples
// tagged with a channel number. The processor pops the head of channel
// addr_in with req_in, and samples io_in in that same cycle.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   s_data/s_chan        producer sample and destination channel
//   s_valid/s_ready      producer handshake; s_ready = !full[s_chan]
//   addr_in/req_in       processor channel select and read strobe
//   io_in                show-ahead head of channel addr_in, 0 when empty
//   empty/full           per-channel occupancy flags
//   uflow                sticky per-channel underflow flags
module proc_io_in_fifo #(
    parameter int NUBITS = 16,
    parameter int NUIOIN = 8,
    parameter int FDEPTH = 4,
    parameter int CHW    = $clog2(NUIOIN),
    parameter int PTRW   = $clog2(FDEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUBITS-1:0] s_data,
    input  logic [CHW-1:0]    s_chan,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [CHW-1:0]    addr_in,
    input  logic              req_in,
    output logic [NUBITS-1:0] io_in,
    output logic [NUIOIN-1:0] empty,
    output logic [NUIOIN-1:0] full,
    output logic [NUIOIN-1:0] uflow
);

    logic [NUBITS-1:0] mem [NUIOIN][FDEPTH];
    logic [PTRW-1:0]   wp  [NUIOIN];
    logic [PTRW-1:0]   rp  [NUIOIN];
    logic [PTRW:0]     cnt [NUIOIN];

    // Channel numbers outside 0..NUIOIN-1 address nothing.
    logic s_chan_ok;
    logic addr_ok;
    logic push;
    logic pop;
    logic under;

    assign s_chan_ok = (32'(s_chan) < NUIOIN);
    assign addr_ok   = (32'(addr_in) < NUIOIN);

    always_comb begin
        for (int c = 0; c < NUIOIN; c++) begin
            empty[c] = (cnt[c] == '0);
            full[c]  = (cnt[c] == (PTRW+1)'(FDEPTH));
        end
    end

    // s_ready looks only at the registered full flag, so a pop in the same
    // cycle does not open a slot for the producer until the next cycle.
    assign s_ready = s_chan_ok && !full[s_chan];

    assign push  = s_valid && s_ready;
    assign pop   = req_in && addr_ok && !empty[addr_in];
    assign under = req_in && addr_ok && empty[addr_in];

    // Empty channels present 0, so stale storage is never visible.
    assign io_in = (addr_ok && !empty[addr_in]) ? mem[addr_in][rp[addr_in]] : '0;

    // Storage needs no reset; it is only observed through io_in.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[s_chan][wp[s_chan]] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUIOIN; c++) begin
                wp[c]    <= '0;
                rp[c]    <= '0;
                cnt[c]   <= '0;
                uflow[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NUIOIN; c++) begin
                logic psh;
                logic pp;
                psh = push && (s_chan == CHW'(c));
                pp  = pop && (addr_in == CHW'(c));
                // Pointers are PTRW bits and FDEPTH is a power of two, so
                // the natural overflow is the modulo wrap.
                if (psh) begin
                    wp[c] <= wp[c] + 1'b1;
                end
                if (pp) begin
                    rp[c] <= rp[c] + 1'b1;
                end
                if (psh && !pp) begin
                    cnt[c] <= cnt[c] + 1'b1;
                end else if (pp && !psh) begin
                    cnt[c] <= cnt[c] - 1'b1;
                end
                if (under && (addr_in == CHW'(c))) begin
                    uflow[c] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_proc_io_in_fifo.sv
// tb/tb_proc_io_in_fifo.sv - scoreboard bench for proc_io_in_fifo
module tb_proc_io_in_fifo;

    localparam int NUBITS = 16;
    localparam int NUIOIN = 8;
    localparam int FDEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUBITS-1:0] s_data = '0;
    logic [2:0]        s_chan = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [2:0]        addr_in = '0;
    logic              req_in = 1'b0;
    logic [NUBITS-1:0] io_in;
    logic [NUIOIN-1:0] empty;
    logic [NUIOIN-1:0] full;
    logic [NUIOIN-1:0] uflow;

    int errors = 0;
    int checks = 0;

    // Reference model: one word queue per channel plus sticky underflow bits.
    logic [NUBITS-1:0] mq [NUIOIN][$];
    logic [NUIOIN-1:0] muf = '0;

    // Scoreboard queues filled by the driver, drained by the monitor.
    logic [NUBITS-1:0] exp_io [$];
    logic              exp_rdy [$];

    proc_io_in_fifo #(.NUBITS(NUBITS), .NUIOIN(NUIOIN), .FDEPTH(FDEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_chan(s_chan), .s_valid(s_valid), .s_ready(s_ready),
        .addr_in(addr_in), .req_in(req_in), .io_in(io_in),
        .empty(empty), .full(full), .uflow(uflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_flags();
        logic [NUIOIN-1:0] e;
        logic [NUIOIN-1:0] f;
        for (int i = 0; i < NUIOIN; i++) begin
            e[i] = (mq[i].size() == 0);
            f[i] = (mq[i].size() == FDEPTH);
        end
        chk("empty", 32'(empty), 32'(e));
        chk("full", 32'(full), 32'(f));
        chk("uflow", 32'(uflow), 32'(muf));
    endtask

    // One processor/producer cycle: inputs are held from just after one edge
    // until just after the next, and the model advances for that edge.
    task automatic cycle(input logic sv, input int sc, input logic [NUBITS-1:0] sd,
                         input logic rq, input int ad);
        int ssz;
        int asz;
        @(posedge clk);
        #1;
        check_flags();
        s_valid = sv;
        s_chan  = 3'(sc);
        s_data  = sd;
        req_in  = rq;
        addr_in = 3'(ad);
        ssz = mq[sc].size();
        asz = mq[ad].size();
        if (rq) exp_io.push_back(asz > 0 ? mq[ad][0] : '0);
        if (sv) exp_rdy.push_back(ssz < FDEPTH);
        if (rq && asz > 0) void'(mq[ad].pop_front());
        if (rq && asz == 0) muf[ad] = 1'b1;
        if (sv && ssz < FDEPTH) mq[sc].push_back(sd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, '0, 1'b0, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (req_in) begin
                if (exp_io.size() == 0) begin
                    chk("io_in_unexpected", 32'(io_in), 32'hFFFF_FFFF);
                end else begin
                    chk("io_in", 32'(io_in), 32'(exp_io.pop_front()));
                end
            end
            if (s_valid) begin
                if (exp_rdy.size() == 0) begin
                    chk("s_ready_unexpected", 32'(s_ready), 32'hFFFF_FFFF);
                end else begin
                    chk("s_ready", 32'(s_ready), 32'(exp_rdy.pop_front()));
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_io_in", 32'(io_in), 32'h0);
        chk("reset_s_ready", 32'(s_ready), 32'h1);
        idle(1);

        // Mid-stream reset discards channel 2 immediately.
        cycle(1'b1, 2, 16'hA001, 1'b0, 0);
        cycle(1'b1, 2, 16'hA002, 1'b0, 0);
        cycle(1'b1, 2, 16'hA003, 1'b0, 0);
        idle(1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_empty2", 32'(empty[2]), 32'h1);
        for (int i = 0; i < NUIOIN; i++) mq[i].delete();
        muf = '0;
        @(negedge clk);
        rst = 1'b0;

        // Fill channel 3, drop a fifth push, drain in order.
        cycle(1'b1, 3, 16'h0011, 1'b0, 0);
        cycle(1'b1, 3, 16'h0022, 1'b0, 0);
        cycle(1'b1, 3, 16'h0033, 1'b0, 0);
        cycle(1'b1, 3, 16'h0044, 1'b0, 0);
        cycle(1'b1, 3, 16'h0055, 1'b0, 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 0, '0, 1'b1, 3);
        idle(1);

        // Wrap-around on channel 0.
        for (int v = 1; v <= 10; v++) begin
            cycle(1'b1, 0, 16'(v), 1'b0, 0);
            cycle(1'b0, 0, '0, 1'b1, 0);
        end

        // Underflow on channel 5, then normal use.
        cycle(1'b0, 0, '0, 1'b1, 5);
        idle(1);
        chk("uflow_only5", 32'(uflow), 32'h20);
        cycle(1'b1, 5, 16'h5555, 1'b0, 0);
        cycle(1'b0, 0, '0, 1'b1, 5);

        // Same-cycle push and pop on a partly filled channel 1.
        cycle(1'b1, 1, 16'h1111, 1'b0, 0);
        cycle(1'b1, 1, 16'h2222, 1'b0, 0);
        cycle(1'b1, 1, 16'hBEEF, 1'b1, 1);
        cycle(1'b0, 0, '0, 1'b1, 1);
        cycle(1'b0, 0, '0, 1'b1, 1);

        // Same-cycle push and pop on empty channel 6.
        cycle(1'b1, 6, 16'h1234, 1'b1, 6);
        cycle(1'b0, 0, '0, 1'b1, 6);

        // Full channel 4: pop succeeds, push refused, retried next cycle.
        for (int i = 0; i < 4; i++) cycle(1'b1, 4, 16'(16'h4000 + i), 1'b0, 0);
        cycle(1'b1, 4, 16'h4444, 1'b1, 4);
        cycle(1'b1, 4, 16'h4444, 1'b0, 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 0, '0, 1'b1, 4);

        // Randomized traffic over a few channels to hit full/empty often.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 16'($urandom),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end
        idle(2);

        chk("scoreboard_io_drained", 32'(exp_io.size()), 32'h0);
        chk("scoreboard_rdy_drained", 32'(exp_rdy.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
